load_writeback_queue: RTL and testbench

LOAD_WRITEBACK_QUEUE -- requirements
Module: load_writeback_queue

---
 rtl/load_writeback_queue.sv | 67 ++++++
 tb/tb_load_writeback_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/load_writeback_queue.sv
// Load writeback queue: buffers load responses in a circular FIFO and drains
// them into the register file, dropping writes aimed at register 0.
module load_writeback_queue #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic                       clk_en,
    input  logic                       In_Valid,
    input  logic [REGADDRBITWIDTH-1:0] In_Address,
    input  logic [DATABITWIDTH-1:0]    In_Data,
    output logic                       In_Ready,
    input  logic                       Drain_Hold,
    output logic                       Mem_Write_En,
    output logic [REGADDRBITWIDTH-1:0] Mem_Write_Address,
    output logic [DATABITWIDTH-1:0]    Mem_Write_Data,
    output logic                       Queue_Empty,
    output logic [$clog2(DEPTH):0]     Queue_Count
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULLCNT = CNTW'(DEPTH);

    logic [REGADDRBITWIDTH-1:0] addrMem [DEPTH];
    logic [DATABITWIDTH-1:0]    dataMem [DEPTH];
    logic [PTRW-1:0]            wrPtr, rdPtr;
    logic [CNTW-1:0]            count;
    logic                       active, push, pop;

    assign active   = clk_en & sync_rst;
    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign In_Ready = active & (count != FULLCNT);
    assign push     = In_Valid & In_Ready;
    assign pop      = active & (count != '0) & ~Drain_Hold;

    assign Mem_Write_Address = addrMem[rdPtr];
    assign Mem_Write_Data    = dataMem[rdPtr];
    assign Mem_Write_En      = pop & (Mem_Write_Address != '0);
    assign Queue_Empty       = (count == '0);
    assign Queue_Count       = count;

    // Entry storage carries no reset; stale slots are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtr] <= In_Address;
            dataMem[wrPtr] <= In_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTRW'(1);
            if (pop)  rdPtr <= rdPtr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_load_writeback_queue.sv
// Randomized bench for load_writeback_queue: a queue-based reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_load_writeback_queue;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 0;
    logic sync_rst, clk_en, In_Valid, Drain_Hold;
    logic [AW-1:0] In_Address;
    logic [DW-1:0] In_Data;
    logic In_Ready, Mem_Write_En, Queue_Empty;
    logic [AW-1:0] Mem_Write_Address;
    logic [DW-1:0] Mem_Write_Data;
    logic [$clog2(DEPTH):0] Queue_Count;

    int checks = 0;
    int errors = 0;
    ent_t q[$];
    bit expPush, expPop;

    load_writeback_queue #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .In_Valid(In_Valid), .In_Address(In_Address), .In_Data(In_Data),
        .In_Ready(In_Ready), .Drain_Hold(Drain_Hold),
        .Mem_Write_En(Mem_Write_En), .Mem_Write_Address(Mem_Write_Address),
        .Mem_Write_Data(Mem_Write_Data), .Queue_Empty(Queue_Empty),
        .Queue_Count(Queue_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model for the inputs currently applied.
    task automatic settle();
        bit rdy, wen;
        #2;
        rdy = clk_en && sync_rst && (q.size() < DEPTH);
        expPop  = clk_en && sync_rst && (q.size() > 0) && !Drain_Hold;
        expPush = In_Valid && rdy;
        wen = expPop && (q[0].a != 0);
        check("In_Ready", {31'b0, In_Ready}, {31'b0, rdy});
        check("Mem_Write_En", {31'b0, Mem_Write_En}, {31'b0, wen});
        check("Queue_Count", 32'(Queue_Count), 32'(q.size()));
        check("Queue_Empty", {31'b0, Queue_Empty}, {31'b0, q.size() == 0});
        if (q.size() > 0) begin
            check("Mem_Write_Address", 32'(Mem_Write_Address), 32'(q[0].a));
            check("Mem_Write_Data", 32'(Mem_Write_Data), 32'(q[0].d));
        end
    endtask

    task automatic advance();
        ent_t e;
        e.a = In_Address;
        e.d = In_Data;
        @(posedge clk);
        if (!sync_rst) q.delete();
        else begin
            if (expPop) void'(q.pop_front());
            if (expPush) q.push_back(e);
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        In_Valid = v; In_Address = a; In_Data = d;
    endtask

    initial begin
        sync_rst = 0; clk_en = 0; In_Valid = 0; Drain_Hold = 0;
        In_Address = 0; In_Data = 0;
        @(posedge clk); #1;
        cycle(); cycle();
        settle();
        check("reset Queue_Empty", {31'b0, Queue_Empty}, 32'd1);
        check("reset Queue_Count", 32'(Queue_Count), 32'd0);
        check("reset In_Ready", {31'b0, In_Ready}, 32'd0);
        advance();

        // Single load
        sync_rst = 1; clk_en = 1;
        drive(1, 4'd3, 16'hBEEF); cycle();
        drive(0, 4'd0, 16'h0); settle();
        check("single wen", {31'b0, Mem_Write_En}, 32'd1);
        check("single addr", 32'(Mem_Write_Address), 32'd3);
        check("single data", 32'(Mem_Write_Data), 32'hBEEF);
        advance();
        settle();
        check("single empty after", {31'b0, Queue_Empty}, 32'd1);
        advance();

        // Fill under Drain_Hold, then drain in order
        Drain_Hold = 1;
        for (int i = 0; i < 5; i++) begin
            drive(1, AW'(i + 1), DW'(16'h100 + i));
            settle();
            if (i == 4) check("fill 5th In_Ready", {31'b0, In_Ready}, 32'd0);
            advance();
        end
        drive(0, 0, 0);
        settle();
        check("fill count", 32'(Queue_Count), 32'd4);
        advance();
        Drain_Hold = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain wen", {31'b0, Mem_Write_En}, 32'd1);
            check("drain addr", 32'(Mem_Write_Address), 32'(i + 1));
            check("drain data", 32'(Mem_Write_Data), 32'(16'h100 + i));
            advance();
        end
        settle();
        check("drain empty", {31'b0, Queue_Empty}, 32'd1);
        advance();

        // Steady count 2 with simultaneous push/pop
        Drain_Hold = 1;
        drive(1, 4'd7, 16'hA000); cycle();
        drive(1, 4'd8, 16'hA001); cycle();
        Drain_Hold = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, AW'(9 + i), DW'(16'hA002 + i));
            settle();
            check("steady count", 32'(Queue_Count), 32'd2);
            advance();
        end
        drive(0, 0, 0);
        cycle(); cycle();

        // Register 0 is popped silently
        drive(1, 4'd0, 16'h1234); cycle();
        drive(1, 4'd5, 16'h0055); settle();
        check("r0 wen", {31'b0, Mem_Write_En}, 32'd0);
        check("r0 count", 32'(Queue_Count), 32'd1);
        advance();
        drive(0, 0, 0); settle();
        check("r5 wen", {31'b0, Mem_Write_En}, 32'd1);
        check("r5 addr", 32'(Mem_Write_Address), 32'd5);
        check("r5 data", 32'(Mem_Write_Data), 32'h0055);
        advance();

        // Stall then reset discards queued entries
        Drain_Hold = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(2 + i), DW'(16'hC000 + i)); cycle();
        end
        drive(1, 4'd6, 16'hDEAD);
        Drain_Hold = 0; clk_en = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall wen", {31'b0, Mem_Write_En}, 32'd0);
            check("stall count", 32'(Queue_Count), 32'd3);
            advance();
        end
        clk_en = 1; sync_rst = 0; drive(0, 0, 0);
        cycle();
        sync_rst = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("post-reset count", 32'(Queue_Count), 32'd0);
            check("post-reset wen", {31'b0, Mem_Write_En}, 32'd0);
            advance();
        end

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            sync_rst   = ($urandom_range(99) >= 2);
            clk_en     = ($urandom_range(99) >= 15);
            Drain_Hold = ($urandom_range(99) < 30);
            drive($urandom_range(99) < 60,
                  ($urandom_range(3) == 0) ? AW'(0) : AW'($urandom),
                  DW'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
